// File: rtl/tone_sequencer_if.sv
// Button request / tone output bundle for tone_sequencer.
// master = requester/tone generator side, slave = sequencer.
interface tone_sequencer_if;
  logic [2:0]  btn;
  logic [14:0] Hz;
  logic        tone_en;
  logic        busy;
  logic [1:0]  melody_id;
  logic [2:0]  note_idx;

  modport master (
    output btn,
    input  Hz, tone_en, busy, melody_id, note_idx
  );

  modport slave (
    input  btn,
    output Hz, tone_en, busy, melody_id, note_idx
  );
endinterface

// File: rtl/tone_sequencer.sv
// ROM-driven melody player: button grant, timed notes and gaps.
// Optional macro TONE_SEQ_REPEAT_EN: replay while the granted button is held.
module tone_sequencer #(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 20
) (
  input  logic         clk,
  input  logic         rst,
  tone_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PLAY, GAP, DONE
  } state_t;

  localparam logic [19:0] PRE_MAX  = 20'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_TICKS - 1);

  state_t      state_q, state_d;
  logic [14:0] hz_q, hz_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic [1:0]  mel_q, mel_d;
  logic [2:0]  idx_q, idx_d;
  logic [19:0] pre_q, pre_d;
  logic [7:0]  tick_q, tick_d;
  logic [7:0]  dur_q, dur_d;

  logic [22:0] entry;
  logic [2:0]  gnt;
  logic        tick_end;
  logic        play_end;
  logic        gap_end;
  logic        rearm;

  // {half_period, dur}; half_period 0 = rest, dur 0 = end
  function automatic logic [22:0] rom(
    input logic [1:0] m,
    input logic [2:0] i
  );
    case ({m, i})
      5'b00_000: rom = {15'd1136, 8'd4};
      5'b00_001: rom = {15'd0,    8'd2};
      5'b00_010: rom = {15'd758,  8'd3};
      5'b01_000: rom = {15'd568,  8'd2};
      5'b01_001: rom = {15'd0,    8'd1};
      5'b01_010: rom = {15'd851,  8'd2};
      5'b10_000: rom = {15'd1517, 8'd1};
      5'b10_001: rom = {15'd1276, 8'd1};
      5'b10_010: rom = {15'd1012, 8'd1};
      5'b10_011: rom = {15'd851,  8'd1};
      5'b10_100: rom = {15'd758,  8'd1};
      5'b10_101: rom = {15'd676,  8'd1};
      5'b10_110: rom = {15'd602,  8'd1};
      5'b10_111: rom = {15'd568,  8'd1};
      default:   rom = '0;
    endcase
  endfunction

  assign entry    = rom(mel_q, idx_q);
  assign gnt      = bus.btn & (~bus.btn + 3'd1);
  assign tick_end = (pre_q == PRE_MAX);
  assign play_end = tick_end && (tick_q == dur_q - 8'd1);
  assign gap_end  = tick_end && (tick_q == GAP_LAST);

`ifdef TONE_SEQ_REPEAT_EN
  logic [3:0] btn4;
  assign btn4  = {1'b0, bus.btn};
  assign rearm = btn4[mel_q];
`else
  assign rearm = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hz_d    = hz_q;
    en_d    = en_q;
    busy_d  = busy_q;
    mel_d   = mel_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    pre_d   = '0;
    tick_d  = '0;
    case (state_q)
      IDLE: begin
        if (|bus.btn) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          idx_d   = '0;
          unique case (1'b1)
            gnt[0]:  mel_d = 2'd0;
            gnt[1]:  mel_d = 2'd1;
            gnt[2]:  mel_d = 2'd2;
            default: mel_d = 2'd3;
          endcase
        end
      end
      LOAD: begin
        if (entry[7:0] == 8'd0) begin
          state_d = DONE;
        end else begin
          hz_d    = entry[22:8];
          en_d    = |entry[22:8];
          dur_d   = entry[7:0];
          state_d = PLAY;
        end
      end
      PLAY: begin
        pre_d  = tick_end ? '0 : pre_q + 20'd1;
        tick_d = tick_end ? tick_q + 8'd1 : tick_q;
        if (play_end) begin
          en_d   = 1'b0;
          pre_d  = '0;
          tick_d = '0;
          if (GAP_TICKS != 0) begin
            state_d = GAP;
          end else if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      GAP: begin
        pre_d  = tick_end ? '0 : pre_q + 20'd1;
        tick_d = tick_end ? tick_q + 8'd1 : tick_q;
        if (gap_end) begin
          pre_d  = '0;
          tick_d = '0;
          if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        en_d = 1'b0;
        if (rearm) begin
          state_d = LOAD;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          mel_d   = 2'd3;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hz_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      mel_q   <= 2'd3;
      idx_q   <= '0;
      pre_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      hz_q    <= hz_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      mel_q   <= mel_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
    end
  end

  assign bus.Hz        = hz_q;
  assign bus.tone_en   = en_q;
  assign bus.busy      = busy_q;
  assign bus.melody_id = mel_q;
  assign bus.note_idx  = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized bench for tone_sequencer against a melody-table timeline model.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_tone_sequencer;
  localparam int TD = 4;
  localparam int GT = 1;

  logic clk = 1'b0;
  logic rst;

  tone_sequencer_if bus ();

  tone_sequencer #(
    .TICK_DIV  (TD),
    .GAP_TICKS (GT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  int hp_t [3][8];
  int dur_t[3][8];
  logic [21:0] q[$];
  logic [14:0] hz_prev;

  function automatic logic [21:0] pk(
    input logic [14:0] h, input logic e, input logic b,
    input logic [1:0] mi, input logic [2:0] ix);
    return {h, e, b, mi, ix};
  endfunction

  function automatic logic [21:0] obs_v();
    return {bus.Hz, bus.tone_en, bus.busy, bus.melody_id, bus.note_idx};
  endfunction

  // Expected per-cycle outputs from the grant edge up to the first idle cycle
  task automatic build(input int m);
    logic [14:0] hz;
    bit fin;
    q.delete();
    hz  = hz_prev;
    fin = 0;
    q.push_back(pk(hz, 1'b0, 1'b1, 2'(m), 3'd0));
    for (int i = 0; i < 8 && !fin; i++) begin
      if (dur_t[m][i] == 0) begin
        q.push_back(pk(hz, 1'b0, 1'b1, 2'(m), 3'(i)));
        fin = 1;
      end else begin
        hz = 15'(hp_t[m][i]);
        repeat (dur_t[m][i] * TD)
          q.push_back(pk(hz, hz != 0, 1'b1, 2'(m), 3'(i)));
        repeat (GT * TD)
          q.push_back(pk(hz, 1'b0, 1'b1, 2'(m), 3'(i)));
        if (i == 7) begin
          q.push_back(pk(hz, 1'b0, 1'b1, 2'(m), 3'd7));
          fin = 1;
        end else begin
          q.push_back(pk(hz, 1'b0, 1'b1, 2'(m), 3'(i + 1)));
        end
      end
    end
    q.push_back(pk(hz, 1'b0, 1'b0, 2'd3, 3'd0));
    hz_prev = hz;
  endtask

  function automatic int low_bit(input logic [2:0] b);
    if (b[0]) return 0;
    if (b[1]) return 1;
    return 2;
  endfunction

  // Call at a falling edge with the DUT idle
  task automatic run(input string tag, input logic [2:0] bv,
                     input bit noise);
    bus.btn = bv;
    build(low_bit(bv));
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      chk(tag, 32'(obs_v()), 32'(q[k]));
      if (noise && (k + 4 < q.size()))
        bus.btn = 3'($urandom_range(0, 7));
      else
        bus.btn = 3'b000;
    end
  endtask

  initial begin
    hp_t  = '{default: 0};
    dur_t = '{default: 0};
    hp_t[0][0] = 1136; dur_t[0][0] = 4;
    hp_t[0][1] = 0;    dur_t[0][1] = 2;
    hp_t[0][2] = 758;  dur_t[0][2] = 3;
    hp_t[1][0] = 568;  dur_t[1][0] = 2;
    hp_t[1][1] = 0;    dur_t[1][1] = 1;
    hp_t[1][2] = 851;  dur_t[1][2] = 2;
    hp_t[2][0] = 1517; hp_t[2][1] = 1276;
    hp_t[2][2] = 1012; hp_t[2][3] = 851;
    hp_t[2][4] = 758;  hp_t[2][5] = 676;
    hp_t[2][6] = 602;  hp_t[2][7] = 568;
    for (int i = 0; i < 8; i++) dur_t[2][i] = 1;

    rst     = 1'b1;
    bus.btn = 3'b000;
    hz_prev = '0;
    #1;
    chk("rst_async", 32'(obs_v()), 32'(pk(0, 0, 0, 2'd3, 0)));
    repeat (2) @(negedge clk);
    chk("rst_idle", 32'(obs_v()), 32'(pk(0, 0, 0, 2'd3, 0)));
    rst = 1'b0;
    @(negedge clk);
    chk("idle", 32'(obs_v()), 32'(pk(0, 0, 0, 2'd3, 0)));

    run("mel0", 3'b001, 1'b0);
    run("prio110", 3'b110, 1'b0);
    run("prio111", 3'b111, 1'b0);
    run("mel2", 3'b100, 1'b0);
    run("mel0_noise", 3'b001, 1'b1);

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_idle", 32'(obs_v()), 32'(pk(hz_prev, 0, 0, 2'd3, 0)));
      end
      run("rnd", 3'($urandom_range(1, 7)), 1'b1);
    end

    // Reset in the middle of entry0 of melody 0
    bus.btn = 3'b001;
    @(negedge clk);
    bus.btn = 3'b000;
    repeat (5) @(negedge clk);
    chk("pre_rst_play", 32'(obs_v()),
        32'(pk(15'd1136, 1, 1, 2'd0, 0)));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid", 32'(obs_v()), 32'(pk(0, 0, 0, 2'd3, 0)));
    @(negedge clk);
    rst = 1'b0;
    hz_prev = '0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst", 32'(obs_v()), 32'(pk(0, 0, 0, 2'd3, 0)));
    end

    // btn[0] held across the end of the melody
    bus.btn = 3'b001;
    build(0);
`ifdef TONE_SEQ_REPEAT_EN
    void'(q.pop_back());
    q.push_back(pk(hz_prev, 0, 1, 2'd0, 0));
`else
    q.push_back(pk(hz_prev, 0, 1, 2'd0, 0));
`endif
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      chk("hold", 32'(obs_v()), 32'(q[k]));
    end
    bus.btn = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("final_idle", 32'(obs_v()), 32'(pk(0, 0, 0, 2'd3, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
